// File: rtl/wc_pkg.sv
// Shared defaults and types for the Winograd F(3,3) tile transmitter.
package wc_pkg;
    localparam int WC_DW   = 10;
    localparam int WC_TILE = 5;
    localparam int WC_STEP = 3;

    typedef enum logic {FILL, EMIT} state_t;

    // Fill count 0..TILE
    typedef logic [2:0] cnt_t;
endpackage

// File: rtl/wc_win_buf.sv
// TILE-entry sample window: write-at-index, shift-down-by-STEP, clear, zero-fill from index.
// win is the registered window; win_nxt is the value it takes at the next edge.
module wc_win_buf
    import wc_pkg::*;
#(
    parameter int DW   = WC_DW,
    parameter int TILE = WC_TILE,
    parameter int STEP = WC_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  cnt_t                 wr_idx,
    input  logic [DW-1:0]        wr_data,
    input  logic                 shift,
    input  logic                 clr,
    input  logic                 pad_en,
    input  cnt_t                 pad_idx,
    output logic [DW*TILE-1:0]   win,
    output logic [DW*TILE-1:0]   win_nxt
);
    logic [TILE-1:0][DW-1:0] q;
    logic [TILE-1:0][DW-1:0] d;

    always_comb begin
        d = q;
        if (clr) begin
            d = '0;
        end else if (shift) begin
            d = q >> (STEP*DW);
        end else begin
            if (wr_en) d[wr_idx] = wr_data;
            // Pad slots after the just-written sample so a short tail reads as zeros
            if (pad_en) begin
                for (int i = 0; i < TILE; i++) begin
                    if (i >= int'(pad_idx)) d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end

    assign win     = q;
    assign win_nxt = d;
endmodule

// File: rtl/wc_tile_tx.sv
// Forms overlapping 5-sample tiles (stride 3) from a serial sample stream for the F(3,3) core.
// Optional WC_TAIL_PAD_EN: zero-pad and emit a short row tail instead of dropping it.
module wc_tile_tx
    import wc_pkg::*;
#(
    parameter int DW   = WC_DW,
    parameter int TILE = WC_TILE,
    parameter int STEP = WC_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_last,
    output logic                 t_valid,
    input  logic                 t_ready,
    output logic [DW*TILE-1:0]   D,
    output logic                 t_last,
    output logic                 drop
);
    state_t state;
    cnt_t   cnt;
    cnt_t   cnt_nxt;
    logic   acc;
    logic   hs;
    logic   full;
    logic   part;
    logic   pad_en;
    logic   clr;
    logic [DW*TILE-1:0] win;
    logic [DW*TILE-1:0] win_nxt;

    assign s_ready = (state == FILL);
    assign t_valid = (state == EMIT);
    assign acc     = s_valid & s_ready;
    assign hs      = t_valid & t_ready;
    assign cnt_nxt = cnt + cnt_t'(1);
    assign full    = acc && (cnt_nxt == cnt_t'(TILE));
    assign part    = acc && s_last && (cnt_nxt < cnt_t'(TILE));

`ifdef WC_TAIL_PAD_EN
    assign pad_en = part;
    assign clr    = hs & t_last;
    assign drop   = 1'b0;
`else
    assign pad_en = 1'b0;
    assign clr    = (hs & t_last) | part;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop <= 1'b0;
        else     drop <= part;
    end
`endif

    wc_win_buf #(.DW(DW), .TILE(TILE), .STEP(STEP)) u_win (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (acc),
        .wr_idx  (cnt),
        .wr_data (s_data),
        .shift   (hs & ~t_last),
        .clr     (clr),
        .pad_en  (pad_en),
        .pad_idx (cnt_nxt),
        .win     (win),
        .win_nxt (win_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FILL;
            cnt    <= '0;
            D      <= '0;
            t_last <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (full) begin
                        D      <= win_nxt;
                        t_last <= s_last;
                        cnt    <= cnt_nxt;
                        state  <= EMIT;
                    end else if (part) begin
`ifdef WC_TAIL_PAD_EN
                        D      <= win_nxt;
                        t_last <= 1'b1;
                        cnt    <= cnt_t'(TILE);
                        state  <= EMIT;
`else
                        cnt    <= '0;
`endif
                    end else if (acc) begin
                        cnt    <= cnt_nxt;
                    end
                end
                EMIT: begin
                    if (t_ready) begin
                        // Keep the TILE-STEP overlap unless the row just ended
                        cnt   <= t_last ? cnt_t'(0) : cnt_t'(TILE - STEP);
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // win is observed only through win_nxt captures; keep it for debug visibility
    logic unused_win;
    assign unused_win = ^win;
endmodule

// File: tb/tb_wc_tile_tx.sv
// Directed self-checking bench for wc_tile_tx.
module tb_wc_tile_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [9:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        t_valid;
    logic        t_ready = 1'b0;
    logic [49:0] D;
    logic        t_last;
    logic        drop;

    int checks = 0;
    int fails  = 0;
    int drop_cnt = 0;
    int both_hi = 0;

    logic [49:0] tq[$];
    logic        tlq[$];

    wc_tile_tx dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .t_valid(t_valid), .t_ready(t_ready), .D(D), .t_last(t_last),
        .drop(drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (t_valid && t_ready) begin
            tq.push_back(D);
            tlq.push_back(t_last);
        end
    end

    always @(negedge clk) begin
        if (drop) drop_cnt++;
        if (s_ready && t_valid) both_hi++;
    end

    task automatic send(input logic [9:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_ready) begin
            fails++;
            $display("FAIL send_timeout sample=%0d s_ready=%b required 1", d, s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (t_valid !== 1'b0) begin fails++; $display("FAIL reset_t_valid got=%b exp=0", t_valid); end
        checks++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        checks++; if (D !== 50'd0) begin fails++; $display("FAIL reset_D got=%h exp=0", D); end
        checks++; if (t_last !== 1'b0) begin fails++; $display("FAIL reset_t_last got=%b exp=0", t_last); end
        checks++; if (drop !== 1'b0) begin fails++; $display("FAIL reset_drop got=%b exp=0", drop); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_steady();
        logic [49:0] exp_d [3];
        logic        exp_l [3];
        int d0 = drop_cnt;
        exp_d[0] = {10'd5, 10'd4, 10'd3, 10'd2, 10'd1};  exp_l[0] = 1'b0;
        exp_d[1] = {10'd8, 10'd7, 10'd6, 10'd5, 10'd4};  exp_l[1] = 1'b0;
        exp_d[2] = {10'd11, 10'd10, 10'd9, 10'd8, 10'd7}; exp_l[2] = 1'b1;
        tq.delete(); tlq.delete();
        t_ready = 1'b1;
        for (int i = 1; i <= 11; i++) send(10'(i), i == 11);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (tq.size() !== 3) begin
            fails++; $display("FAIL steady_count got=%0d exp=3", tq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (tq[i] !== exp_d[i]) begin fails++; $display("FAIL steady_D%0d got=%h exp=%h", i, tq[i], exp_d[i]); end
                checks++; if (tlq[i] !== exp_l[i]) begin fails++; $display("FAIL steady_last%0d got=%b exp=%b", i, tlq[i], exp_l[i]); end
            end
        end
        checks++; if (drop_cnt !== d0) begin fails++; $display("FAIL steady_drop got=%0d exp=%0d", drop_cnt, d0); end
    endtask

    task automatic test_backpressure();
        logic [49:0] e0 = {10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
        logic [49:0] e1 = {10'd8, 10'd7, 10'd6, 10'd5, 10'd4};
        int bad = 0;
        tq.delete(); tlq.delete();
        t_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(10'(i), 1'b0);
        s_valid = 1'b1; s_data = 10'd6; s_last = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (t_valid !== 1'b1 || s_ready !== 1'b0 || D !== e0) begin
                bad++;
                $display("FAIL bp_cycle%0d t_valid=%b s_ready=%b D=%h exp 1/0/%h", c, t_valid, s_ready, D, e0);
            end
        end
        checks++; if (bad != 0) fails++;
        t_ready = 1'b1;
        send(10'd6, 1'b0);
        send(10'd7, 1'b0);
        send(10'd8, 1'b1);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (tq.size() !== 2) begin
            fails++; $display("FAIL bp_count got=%0d exp=2", tq.size());
        end else begin
            checks++; if (tq[0] !== e0 || tlq[0] !== 1'b0) begin fails++; $display("FAIL bp_tile0 got=%h/%b exp=%h/0", tq[0], tlq[0], e0); end
            checks++; if (tq[1] !== e1 || tlq[1] !== 1'b1) begin fails++; $display("FAIL bp_tile1 got=%h/%b exp=%h/1", tq[1], tlq[1], e1); end
        end
    endtask

    task automatic test_partial();
        logic [49:0] e0 = {10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
        int d0 = drop_cnt;
        tq.delete(); tlq.delete();
        t_ready = 1'b1;
        for (int i = 1; i <= 7; i++) send(10'(i), i == 7);
`ifdef WC_TAIL_PAD_EN
        begin
            logic [49:0] e1 = {10'd0, 10'd7, 10'd6, 10'd5, 10'd4};
            repeat (3) @(posedge clk); #1;
            checks++;
            if (tq.size() !== 2) begin
                fails++; $display("FAIL pad_count got=%0d exp=2", tq.size());
            end else begin
                checks++; if (tq[0] !== e0 || tlq[0] !== 1'b0) begin fails++; $display("FAIL pad_tile0 got=%h/%b exp=%h/0", tq[0], tlq[0], e0); end
                checks++; if (tq[1] !== e1 || tlq[1] !== 1'b1) begin fails++; $display("FAIL pad_tile1 got=%h/%b exp=%h/1", tq[1], tlq[1], e1); end
            end
            checks++; if (drop_cnt !== d0) begin fails++; $display("FAIL pad_drop got=%0d exp=%0d", drop_cnt, d0); end
        end
`else
        checks++; if (drop !== 1'b1) begin fails++; $display("FAIL tail_drop_pulse got=%b exp=1", drop); end
        checks++; if (dut.cnt !== 3'd0) begin fails++; $display("FAIL tail_cnt got=%0d exp=0", dut.cnt); end
        @(posedge clk); #1;
        checks++; if (drop !== 1'b0) begin fails++; $display("FAIL tail_drop_end got=%b exp=0", drop); end
        repeat (3) @(posedge clk); #1;
        checks++; if (drop_cnt !== d0 + 1) begin fails++; $display("FAIL tail_drop_count got=%0d exp=%0d", drop_cnt, d0 + 1); end
        checks++;
        if (tq.size() !== 1) begin
            fails++; $display("FAIL tail_count got=%0d exp=1", tq.size());
        end else begin
            checks++; if (tq[0] !== e0 || tlq[0] !== 1'b0) begin fails++; $display("FAIL tail_tile0 got=%h/%b exp=%h/0", tq[0], tlq[0], e0); end
        end
`endif
    endtask

    task automatic test_row_boundary();
        logic [49:0] ea = {10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
        logic [49:0] eb = {10'd104, 10'd103, 10'd102, 10'd101, 10'd100};
        tq.delete(); tlq.delete();
        t_ready = 1'b1;
        for (int i = 1; i <= 5; i++) send(10'(i), i == 5);
        for (int i = 100; i <= 104; i++) send(10'(i), i == 104);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (tq.size() !== 2) begin
            fails++; $display("FAIL row_count got=%0d exp=2", tq.size());
        end else begin
            checks++; if (tq[0] !== ea || tlq[0] !== 1'b1) begin fails++; $display("FAIL row_a got=%h/%b exp=%h/1", tq[0], tlq[0], ea); end
            checks++; if (tq[1] !== eb || tlq[1] !== 1'b1) begin fails++; $display("FAIL row_b got=%h/%b exp=%h/1", tq[1], tlq[1], eb); end
        end
    endtask

    task automatic test_reset_mid();
        logic [49:0] e = {10'd14, 10'd13, 10'd12, 10'd11, 10'd10};
        t_ready = 1'b1;
        for (int i = 1; i <= 3; i++) send(10'(i), 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (t_valid !== 1'b0 || s_ready !== 1'b1) begin fails++; $display("FAIL rstmid_hs got=%b/%b exp=0/1", t_valid, s_ready); end
        checks++; if (D !== 50'd0 || t_last !== 1'b0 || drop !== 1'b0) begin fails++; $display("FAIL rstmid_out D=%h t_last=%b drop=%b exp 0", D, t_last, drop); end
        checks++; if (dut.cnt !== 3'd0) begin fails++; $display("FAIL rstmid_cnt got=%0d exp=0", dut.cnt); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tq.delete(); tlq.delete();
        for (int i = 10; i <= 14; i++) send(10'(i), i == 14);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (tq.size() !== 1) begin
            fails++; $display("FAIL rstmid_count got=%0d exp=1", tq.size());
        end else begin
            checks++; if (tq[0] !== e || tlq[0] !== 1'b1) begin fails++; $display("FAIL rstmid_tile got=%h/%b exp=%h/1", tq[0], tlq[0], e); end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_hi !== 0) begin fails++; $display("FAIL ready_valid_overlap got=%0d exp=0", both_hi); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_backpressure();
        test_partial();
        test_row_boundary();
        test_reset_mid();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
